booth_result_collector: RTL and testbench
=========================================

Name: booth_result_collector

Overview:
Downstream consumer of the Booth multiplier datapath. Captures the two result halves the multiplier control unit drives serially onto the shared tristate result bus (A = high half, then Q = low half, then stop pulse). Assembles them into one 2*WIDTH signed product and queues it in a small FIFO with a valid/ready output handshake. Provides back-pressure (can_start) so the next multiplication is not launched when no slot is free.

Parameters:
WIDTH, 8, operand width; the product is 2*WIDTH bits.
DEPTH, 2, number of FIFO entries (>=1); LW = $clog2(DEPTH+1).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
bus_data  in  WIDTH  shared result bus; may be Z/X except in strobe cycles
cap_hi  in  1  control strobe c[6]: bus carries A (high half)
cap_lo  in  1  control strobe c[7]: bus carries Q (low half)
done  in  1  stop pulse from the control unit
clr_err  in  1  synchronous clear of the sticky error flags
prod_data  out  2*WIDTH  FIFO head {A,Q}
prod_valid  out  1  head valid
prod_ready  in  1  consumer accepts head
can_start  out  1  high when level < DEPTH
level  out  LW  FIFO occupancy
overflow  out  1  sticky: a completed product was dropped
seq_err  out  1  sticky: strobe protocol violation

Behaviour:
- Reset: FSM=WAIT_HI, hi/lo regs=0, level=0, prod_valid=0, prod_data=0, can_start=1, overflow=0, seq_err=0. Reset mid-assembly discards the partial result.
- bus_data is sampled only on cycles where cap_hi or cap_lo is high; hi/lo regs hold their value otherwise (X/Z on the bus never propagates).
- FSM states: WAIT_HI, WAIT_LO, WAIT_DONE.
  - WAIT_HI: cap_hi -> hi<=bus, go WAIT_LO. cap_lo or done -> seq_err<=1, stay.
  - WAIT_LO: cap_lo -> lo<=bus, go WAIT_DONE. cap_hi -> hi overwritten, seq_err<=1, stay. done -> seq_err<=1, go WAIT_HI.
  - WAIT_DONE: done -> push {hi,lo}, go WAIT_HI. cap_hi -> seq_err<=1, hi<=bus, go WAIT_LO. cap_lo -> seq_err<=1, lo overwritten, stay.
  - cap_hi and cap_lo high in the same cycle, in any state -> seq_err<=1, no capture, go WAIT_HI. Any combination involving done with a strobe is also a violation and is handled the same way.
- Push/pop:
  - Pop = prod_valid & prod_ready.
  - Push is accepted if level < DEPTH, or if a pop occurs in the same cycle (push-while-full-with-pop is legal).
  - Otherwise the product is dropped, overflow<=1, FIFO unchanged.
- Latency: done in cycle N -> prod_valid=1 with that data at N+1 when the FIFO was empty. The FIFO is first-word-fall-through and registered; no combinational path from done or bus_data to any output.
- Ordering: strict FIFO order. prod_data stays stable while prod_valid & !prod_ready.
- Level is updated as level +1 / -1 / unchanged on push-only / pop-only / both. can_start = (level < DEPTH) from registered level.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Error flags:
  - overflow and seq_err hold until clr_err.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).

Decomposition:
- booth_pkg holds:
  - the collector state enum (WAIT_HI, WAIT_LO, WAIT_DONE);
  - control-word bit index constants C_LOAD_M=0, C_LOAD_Q=1, C_ADD=2, C_SUB=3, C_SHIFT=4, C_CNT=5, C_OUT_A=6, C_OUT_Q=7, shared with the control unit.
- One sub-module: booth_result_fifo, a parameterised FWFT sync FIFO (WIDTH*2, DEPTH) with push, pop, level, full and empty. The collector top owns the FSM, the hi/lo regs and the error flags.

Test Plan:
1. Single product, -3*5 (WIDTH=8): cap_hi with bus=0xFF, cap_lo with bus=0xF1, done, prod_ready=1 -> prod_valid=1 one cycle after done, prod_data=0xFFF1, level returns to 0, no errors.
2. Back-pressure, DEPTH=2, prod_ready=0: complete three products 0x0001, 0x0002, 0x0003 -> can_start=0 after the second push, level=2, overflow=1 after the third done. Releasing ready then pops 0x0001 then 0x0002 only.
3. Full with simultaneous pop: at level=2, done and pop in the same cycle -> level stays 2, no overflow, the new product is the last entry popped.
4. Protocol error: cap_lo (bus=0x55) in WAIT_HI -> seq_err=1, nothing pushed. Then a normal 0x12/0x34 sequence still yields 0x1234. clr_err -> seq_err=0.
5. Reset mid-assembly: cap_hi=0xAB, then assert rst_n=0 -> all outputs return to reset values. A later cap_lo=0xCD with done -> seq_err=1, no push.
6. Bus Z/X between strobes: drive bus=Z except in strobe cycles -> prod_data contains no X.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier slice: result-collector FSM
// states and the control-word bit positions used by the control unit.
package booth_pkg;

  typedef enum logic [1:0] {
    WAIT_HI   = 2'd0,
    WAIT_LO   = 2'd1,
    WAIT_DONE = 2'd2
  } collector_state_e;

  localparam int C_LOAD_M = 0;
  localparam int C_LOAD_Q = 1;
  localparam int C_ADD    = 2;
  localparam int C_SUB    = 3;
  localparam int C_SHIFT  = 4;
  localparam int C_CNT    = 5;
  localparam int C_OUT_A  = 6;
  localparam int C_OUT_Q  = 7;

endpackage

// File: rtl/booth_result_collector_if.sv
// Bundle between the multiplier control unit / product consumer and the
// result collector. The collector uses the slave view.
interface booth_result_collector_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   bus_data;
  logic               cap_hi;
  logic               cap_lo;
  logic               done;
  logic               clr_err;
  logic [2*WIDTH-1:0] prod_data;
  logic               prod_valid;
  logic               prod_ready;
  logic               can_start;
  logic [LW-1:0]      level;
  logic               overflow;
  logic               seq_err;

  modport slave (
    input  bus_data, cap_hi, cap_lo, done, clr_err, prod_ready,
    output prod_data, prod_valid, can_start, level, overflow, seq_err
  );

  modport master (
    output bus_data, cap_hi, cap_lo, done, clr_err, prod_ready,
    input  prod_data, prod_valid, can_start, level, overflow, seq_err
  );
endinterface

// File: rtl/booth_result_fifo.sv
// First-word-fall-through synchronous FIFO; the head is read straight from
// storage, and level/full/empty are all registered.
module booth_result_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic [LW-1:0] w_level_nxt;

  // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_level_nxt = r_level;
    case ({i_push, i_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == LW'(0));
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/booth_result_collector.sv
// Captures the serial A/Q result halves from the shared bus, assembles the
// 2*WIDTH product and queues it behind a valid/ready handshake.
module booth_result_collector
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  booth_result_collector_if.slave       bus
);
  localparam int LW = $clog2(DEPTH + 1);

  collector_state_e r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_overflow;
  logic             r_seq_err;

  logic             w_multi;
  logic             w_viol;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [LW-1:0]    w_level;
  logic [2*WIDTH-1:0] w_head;

  // Protocol decode: multi-strobe cycles are always violations.
  always_comb begin
    w_multi = (bus.cap_hi & bus.cap_lo) | (bus.done & (bus.cap_hi | bus.cap_lo));
    w_viol  = 1'b0;
    case (r_state)
      WAIT_HI:   w_viol = w_multi | bus.cap_lo | bus.done;
      WAIT_LO:   w_viol = w_multi | bus.cap_hi | bus.done;
      WAIT_DONE: w_viol = w_multi | bus.cap_hi | bus.cap_lo;
      default:   w_viol = 1'b1;
    endcase
    if ((r_state == WAIT_DONE) && bus.done && !w_multi) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
  end

  // A full FIFO still accepts a product when the head leaves this cycle.
  always_comb begin
    w_pop     = !w_empty & bus.prod_ready;
    w_push_ok = w_push & (!w_full | w_pop);
    w_drop    = w_push & w_full & !w_pop;
  end

  // Collector FSM; the bus is sampled only under a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_HI;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_multi) begin
      r_state <= WAIT_HI;
    end else begin
      case (r_state)
        WAIT_HI: begin
          if (bus.cap_hi) begin
            r_hi    <= bus.bus_data;
            r_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (bus.cap_hi) begin
            r_hi <= bus.bus_data;
          end else if (bus.cap_lo) begin
            r_lo    <= bus.bus_data;
            r_state <= WAIT_DONE;
          end else if (bus.done) begin
            r_state <= WAIT_HI;
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            r_state <= WAIT_HI;
          end else if (bus.cap_hi) begin
            r_hi    <= bus.bus_data;
            r_state <= WAIT_LO;
          end else if (bus.cap_lo) begin
            r_lo <= bus.bus_data;
          end
        end
        default: r_state <= WAIT_HI;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_viol) begin
        r_seq_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  booth_result_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_data  ({r_hi, r_lo}),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.prod_data  = w_head;
  assign bus.prod_valid = !w_empty;
  assign bus.can_start  = !w_full;
  assign bus.level      = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.seq_err    = r_seq_err;

endmodule

// File: tb/tb_booth_result_collector.sv
// Directed bench for booth_result_collector: expected products go into a
// scoreboard queue, a negedge monitor pops and compares on each handshake.
module tb_booth_result_collector;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] sb_q[$];

  booth_result_collector_if #(.WIDTH(8), .DEPTH(2)) dut_if ();

  booth_result_collector #(.WIDTH(8), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle with the given strobes; bus floats afterwards.
  task automatic step(input logic ch, input logic cl, input logic dn, input logic [7:0] b);
    dut_if.cap_hi   = ch;
    dut_if.cap_lo   = cl;
    dut_if.done     = dn;
    dut_if.bus_data = b;
    @(posedge clk);
    #1;
    dut_if.cap_hi   = 1'b0;
    dut_if.cap_lo   = 1'b0;
    dut_if.done     = 1'b0;
    dut_if.bus_data = 'z;
  endtask

  task automatic product(input logic [7:0] hi, input logic [7:0] lo);
    step(1'b1, 1'b0, 1'b0, hi);
    step(1'b0, 1'b1, 1'b0, lo);
    step(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic clear_err();
    dut_if.clr_err = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    dut_if.clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},    32'(dut_if.level), 32'd0);
    check({tag, "_valid"},    32'(dut_if.prod_valid), 32'd0);
    check({tag, "_data"},     32'(dut_if.prod_data), 32'd0);
    check({tag, "_canstart"}, 32'(dut_if.can_start), 32'd1);
    check({tag, "_ovf"},      32'(dut_if.overflow), 32'd0);
    check({tag, "_seqerr"},   32'(dut_if.seq_err), 32'd0);
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && dut_if.prod_valid && dut_if.prod_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 32'(dut_if.prod_data), 32'hDEAD_BEEF);
      end else begin
        check("prod_data", 32'(dut_if.prod_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    dut_if.cap_hi     = 1'b0;
    dut_if.cap_lo     = 1'b0;
    dut_if.done       = 1'b0;
    dut_if.clr_err    = 1'b0;
    dut_if.prod_ready = 1'b0;
    dut_if.bus_data   = 'z;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: -3 * 5 = 0xFFF1
    dut_if.prod_ready = 1'b1;
    sb_q.push_back(16'hFFF1);
    product(8'hFF, 8'hF1);
    check("t1_valid_latency", 32'(dut_if.prod_valid), 32'd1);
    idle(1);
    check("t1_level", 32'(dut_if.level), 32'd0);
    check("t1_seqerr", 32'(dut_if.seq_err), 32'd0);
    check("t1_ovf", 32'(dut_if.overflow), 32'd0);

    // 2: back-pressure and overflow
    dut_if.prod_ready = 1'b0;
    sb_q.push_back(16'h0001);
    product(8'h00, 8'h01);
    check("t2_canstart_1", 32'(dut_if.can_start), 32'd1);
    sb_q.push_back(16'h0002);
    product(8'h00, 8'h02);
    check("t2_canstart_2", 32'(dut_if.can_start), 32'd0);
    check("t2_level_2", 32'(dut_if.level), 32'd2);
    check("t2_ovf_before", 32'(dut_if.overflow), 32'd0);
    check("t2_head_stable", 32'(dut_if.prod_data), 32'h0001);
    product(8'h00, 8'h03);
    check("t2_ovf_after", 32'(dut_if.overflow), 32'd1);
    check("t2_level_after", 32'(dut_if.level), 32'd2);
    clear_err();
    check("t2_ovf_clr", 32'(dut_if.overflow), 32'd0);
    dut_if.prod_ready = 1'b1;
    idle(3);
    check("t2_level_drained", 32'(dut_if.level), 32'd0);

    // 3: push while full with a simultaneous pop
    dut_if.prod_ready = 1'b0;
    sb_q.push_back(16'h0011);
    product(8'h00, 8'h11);
    sb_q.push_back(16'h0022);
    product(8'h00, 8'h22);
    sb_q.push_back(16'h0033);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h33);
    dut_if.prod_ready = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("t3_level", 32'(dut_if.level), 32'd2);
    check("t3_ovf", 32'(dut_if.overflow), 32'd0);
    idle(3);
    check("t3_level_drained", 32'(dut_if.level), 32'd0);

    // 4: protocol error, recovery, clear
    step(1'b0, 1'b1, 1'b0, 8'h55);
    check("t4_seqerr", 32'(dut_if.seq_err), 32'd1);
    check("t4_level", 32'(dut_if.level), 32'd0);
    sb_q.push_back(16'h1234);
    product(8'h12, 8'h34);
    idle(2);
    clear_err();
    check("t4_seqerr_clr", 32'(dut_if.seq_err), 32'd0);

    // 5: reset mid-assembly
    step(1'b1, 1'b0, 1'b0, 8'hAB);
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 8'hCD);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("t5_seqerr", 32'(dut_if.seq_err), 32'd1);
    check("t5_valid", 32'(dut_if.prod_valid), 32'd0);
    check("t5_level", 32'(dut_if.level), 32'd0);
    clear_err();

    // 6: bus floats between strobes
    sb_q.push_back(16'h5AC3);
    product(8'h5A, 8'hC3);
    check("t6_no_x", 32'($isunknown(dut_if.prod_data)), 32'd0);
    idle(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
